fp_div: RTL
===========

FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have no parameters; formats are fixed to IEEE-754 binary32.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  operand strobe; sampled each rising edge.
REQ-005 i_a  input  32  dividend, binary32 (sign, exp[30:23], frac[22:0]).
REQ-006 i_b  input  32  divisor, binary32.
REQ-007 o_valid  output  1  high while o_result holds a completed quotient.
REQ-008 o_busy  output  1  high while a division is in progress (state CALC).
REQ-009 o_result  output  32  binary32 quotient i_a / i_b.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-011 IDLE/DONE + i_valid=1 -> SHALL capture i_a and i_b into internal registers, clear count, go to CALC; o_valid low the next cycle.
REQ-012 IDLE/DONE + i_valid=0 -> SHALL hold state; DONE holds o_result and o_valid=1.
REQ-013 CALC -> SHALL ignore i_valid (no restart, no queueing); o_busy=1.
REQ-014 CALC SHALL run exactly 25 iterations (count 0..24), one quotient bit per cycle, restoring division.
REQ-015 Mantissas SHALL be {1,frac} (24 bits); remainder register 26 bits, initialised to dividend mantissa.
REQ-016 Each iteration: remainder >= divisor mantissa -> quotient bit 1 and subtract; else bit 0; then remainder shifts left 1.
REQ-017 Normalisation: q[24]=1 -> frac=q[23:1], exp offset 0; q[24]=0 -> frac=q[22:0], exp offset -1.
REQ-018 Exponent SHALL be computed 10-bit signed: a_exp - b_exp + 127 + offset.
REQ-019 Rounding SHALL be truncation toward zero; the remainder is discarded.
REQ-020 Sign SHALL be a_sign XOR b_sign for all non-NaN results.
REQ-021 Exponent result >= 255 -> signed infinity (exp 0xFF, frac 0).
REQ-022 Exponent result <= 0 -> signed zero (flush, no subnormals).
REQ-023 Subnormal inputs (exp 0, frac != 0) SHALL be treated as signed zero.
REQ-024 Special cases SHALL be classified at capture and override: either NaN, 0/0 or inf/inf -> 0x7FC00000; x/0 (x finite nonzero) -> signed inf; inf/finite -> signed inf; 0/nonzero or finite/inf -> signed zero.
REQ-025 Latency SHALL be fixed for all operands, special cases included: o_valid rises 26 edges after the capturing edge (1 capture, 25 CALC).
REQ-026 On the last CALC edge, o_result and o_valid SHALL update together and state SHALL go to DONE.
REQ-027 A new capture from DONE SHALL drop o_valid one edge later; o_result keeps the old value until the new result is written.

Reset
REQ-028 While i_rst_n=0: state IDLE, count 0, o_valid 0, o_busy 0, o_result 0x00000000, operand/remainder/quotient registers 0.
REQ-029 Reset asserted mid-CALC SHALL abort the operation with no output; after release the block waits in IDLE for i_valid.
REQ-030 The first rising edge after release SHALL be able to capture an operand.

Structure
REQ-031 Shared package fp_pkg SHALL hold EXP_BIAS=127, EXP_W=8, FRAC_W=23, canonical NaN 0x7FC00000, infinity exponent 0xFF, and the IDLE/CALC/DONE state encoding shared with fp_mul.
REQ-032 One combinational sub-module fp_classify SHALL decode a binary32 into sign/exp/frac and the flags is_zero, is_inf, is_nan; fp_div instantiates it twice.
REQ-033 Iteration datapath, exponent logic and FSM SHALL reside in fp_div (120-400 lines total).

Verification
REQ-034 0x40C00000 / 0x40000000 (6/2) -> 0x40400000 after exactly 26 edges; o_busy high 25 cycles.
REQ-035 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated, exp offset -1 path).
REQ-036 0xC0000000 / 0x00000000 -> 0xFF800000; 0x00000000 / 0x00000000 -> 0x7FC00000; latency still 26.
REQ-037 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow); 0x00800000 / 0x4B000000 -> 0x00000000 (underflow flush).
REQ-038 i_valid pulsed at cycles 0 and 5 -> second ignored, one result at 26; back-to-back from DONE -> o_valid low for 26 cycles, then second result.
REQ-039 i_rst_n pulsed low at CALC count 10 -> o_valid never asserts and o_result=0; a new operand after release completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary32 constants and FSM state encoding for the floating-point
// arithmetic blocks (fp_div, fp_mul).
package fp_pkg;

    localparam int          EXP_BIAS  = 127;
    localparam int          EXP_W     = 8;
    localparam int          FRAC_W    = 23;
    localparam logic [31:0] FP_NAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_INF   = 8'hFF;
    localparam logic [4:0]  LAST_ITER = 5'd24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    function automatic logic [31:0] fp_pack(
        input logic              sign,
        input logic [EXP_W-1:0]  exp,
        input logic [FRAC_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 field decoder; subnormals are reported as zero so
// downstream logic flushes them.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]       i_x,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_is_zero,
    output logic              o_is_inf,
    output logic              o_is_nan
);

    assign o_sign    = i_x[31];
    assign o_exp     = i_x[30:23];
    assign o_frac    = i_x[22:0];
    assign o_is_zero = (i_x[30:23] == 8'h00);
    assign o_is_inf  = (i_x[30:23] == EXP_INF) && (i_x[22:0] == 23'd0);
    assign o_is_nan  = (i_x[30:23] == EXP_INF) && (i_x[22:0] != 23'd0);

endmodule

// File: rtl/fp_div.sv
// Binary32 divider: restoring mantissa division, one quotient bit per cycle,
// fixed 26-edge latency, truncating rounding and flush-to-zero.
module fp_div
    import fp_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_valid,
    output logic        o_busy,
    output logic [31:0] o_result
);

    logic              a_sign_s, b_sign_s;
    logic [EXP_W-1:0]  a_exp_s, b_exp_s;
    logic [FRAC_W-1:0] a_frac_s, b_frac_s;
    logic              a_zero_s, a_inf_s, a_nan_s;
    logic              b_zero_s, b_inf_s, b_nan_s;

    fp_classify u_class_a (
        .i_x       (i_a),
        .o_sign    (a_sign_s),
        .o_exp     (a_exp_s),
        .o_frac    (a_frac_s),
        .o_is_zero (a_zero_s),
        .o_is_inf  (a_inf_s),
        .o_is_nan  (a_nan_s)
    );

    fp_classify u_class_b (
        .i_x       (i_b),
        .o_sign    (b_sign_s),
        .o_exp     (b_exp_s),
        .o_frac    (b_frac_s),
        .o_is_zero (b_zero_s),
        .o_is_inf  (b_inf_s),
        .o_is_nan  (b_nan_s)
    );

    fsm_state_e        state_r;
    logic [4:0]        count_r;
    logic              sign_r;
    logic [EXP_W-1:0]  a_exp_r, b_exp_r;
    logic [FRAC_W-1:0] b_frac_r;
    logic [25:0]       rem_r;
    logic [24:0]       quo_r;
    logic              spec_hit_r;
    logic [31:0]       spec_val_r;
    logic              valid_r, busy_r;
    logic [31:0]       result_r;

    logic              spec_hit_s;
    logic [31:0]       spec_val_s;
    logic              q_bit_s;
    logic [25:0]       div_mant_s, rem_sub_s, rem_next_s;
    logic [24:0]       quo_next_s;
    logic [FRAC_W-1:0] frac_s;
    logic signed [9:0] exp_base_s, exp_s;
    logic [31:0]       result_s;

    // Special-operand classification, resolved at capture time
    always_comb begin
        spec_hit_s = 1'b1;
        spec_val_s = FP_NAN;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_val_s = FP_NAN;
        end else if (a_inf_s || b_zero_s) begin
            spec_val_s = fp_pack(a_sign_s ^ b_sign_s, EXP_INF, 23'd0);
        end else if (a_zero_s || b_inf_s) begin
            spec_val_s = fp_pack(a_sign_s ^ b_sign_s, 8'h00, 23'd0);
        end else begin
            spec_hit_s = 1'b0;
            spec_val_s = 32'h0000_0000;
        end
    end

    // One restoring-division step on the current remainder
    always_comb begin
        div_mant_s = {2'b00, 1'b1, b_frac_r};
        q_bit_s    = (rem_r >= div_mant_s);
        if (q_bit_s) begin
            rem_sub_s = rem_r - div_mant_s;
        end else begin
            rem_sub_s = rem_r;
        end
        rem_next_s = {rem_sub_s[24:0], 1'b0};
        quo_next_s = {quo_r[23:0], q_bit_s};
    end

    // Normalisation, exponent arithmetic and final result selection
    always_comb begin
        exp_base_s = $signed({2'b00, a_exp_r}) - $signed({2'b00, b_exp_r})
                   + $signed(10'(EXP_BIAS));
        if (quo_next_s[24]) begin
            frac_s = quo_next_s[23:1];
            exp_s  = exp_base_s;
        end else begin
            frac_s = quo_next_s[22:0];
            exp_s  = exp_base_s - 10'sd1;
        end
        if (spec_hit_r) begin
            result_s = spec_val_r;
        end else if (exp_s >= 10'sd255) begin
            result_s = fp_pack(sign_r, EXP_INF, 23'd0);
        end else if (exp_s <= 10'sd0) begin
            result_s = fp_pack(sign_r, 8'h00, 23'd0);
        end else begin
            result_s = fp_pack(sign_r, exp_s[7:0], frac_s);
        end
    end

    // Control FSM with operand capture, iteration registers and outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            count_r    <= 5'd0;
            sign_r     <= 1'b0;
            a_exp_r    <= 8'h00;
            b_exp_r    <= 8'h00;
            b_frac_r   <= 23'd0;
            rem_r      <= 26'd0;
            quo_r      <= 25'd0;
            spec_hit_r <= 1'b0;
            spec_val_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            result_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (i_valid) begin
                        state_r    <= ST_CALC;
                        count_r    <= 5'd0;
                        sign_r     <= a_sign_s ^ b_sign_s;
                        a_exp_r    <= a_exp_s;
                        b_exp_r    <= b_exp_s;
                        b_frac_r   <= b_frac_s;
                        rem_r      <= {2'b00, 1'b1, a_frac_s};
                        quo_r      <= 25'd0;
                        spec_hit_r <= spec_hit_s;
                        spec_val_r <= spec_val_s;
                        valid_r    <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    if (count_r == LAST_ITER) begin
                        state_r  <= ST_DONE;
                        result_r <= result_s;
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                    end else begin
                        count_r <= count_r + 5'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid  = valid_r;
    assign o_busy   = busy_r;
    assign o_result = result_r;

endmodule
